// File: rtl/mac_acc_pkg.sv
// Shared types and width helpers for the MAC accumulator stage.
// State encoding is fixed at 2 bits: IDLE=00, ACC=01, HOLD=10.
package mac_acc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAcc  = 2'b01,
    StHold = 2'b10
  } state_e;

  localparam int unsigned DefW = 16;
  localparam int unsigned DefG = 8;
  localparam int unsigned DefN = 8;

  function automatic int unsigned acc_width(int unsigned w, int unsigned g);
    return 2 * w + g;
  endfunction

  // Counter needs at least one bit, even when N == 1.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_acc_if.sv
// Product input stream and result output stream of the accumulator stage.
// The slave modport is the accumulator; the master modport is its environment.
interface mac_acc_if #(
  parameter int unsigned W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2*W-1:0]    p;
  logic              ser;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    y;
  logic              ovf;

  modport slave (
    input  in_valid, p, ser, out_ready,
    output in_ready, out_valid, y, ovf
  );

  modport master (
    output in_valid, p, ser, out_ready,
    input  in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/mac_acc_sat_trunc.sv
// Combinational signed saturation from InW to OutW bits (InW > OutW).
// sat_o flags that the input lay outside the OutW signed range.
module mac_acc_sat_trunc #(
  parameter int unsigned InW  = 40,
  parameter int unsigned OutW = 32
) (
  input  logic [InW-1:0]  a_i,
  output logic [OutW-1:0] y_o,
  output logic            sat_o
);

  localparam logic signed [InW-1:0] MaxVal = {{(InW-OutW+1){1'b0}}, {(OutW-1){1'b1}}};
  localparam logic signed [InW-1:0] MinVal = {{(InW-OutW+1){1'b1}}, {(OutW-1){1'b0}}};
  localparam logic [OutW-1:0]       MaxOut = {1'b0, {(OutW-1){1'b1}}};
  localparam logic [OutW-1:0]       MinOut = {1'b1, {(OutW-1){1'b0}}};

  logic signed [InW-1:0] a_s;
  assign a_s = $signed(a_i);

  always_comb begin
    y_o   = a_i[OutW-1:0];
    sat_o = 1'b0;
    if (a_s > MaxVal) begin
      y_o   = MaxOut;
      sat_o = 1'b1;
    end else if (a_s < MinVal) begin
      y_o   = MinOut;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_acc.sv
// Guard-bit accumulator: sums N signed products, saturates to 2W bits and
// holds the result in a one-deep valid/ready output register.
module mac_acc
  import mac_acc_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned G = DefG,
  parameter int unsigned N = DefN
) (
  input  logic      clk_i,
  input  logic      arst_ni,
  input  logic      ce_i,
  input  logic      start_i,
  mac_acc_if.slave  bus,
  output logic      busy_o
);

  localparam int unsigned AccW = acc_width(W, G);
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e            state_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              sticky_q;
  logic [2*W-1:0]    y_q;
  logic              ovf_q;
  logic              out_valid_q;

  logic [AccW-1:0]   acc_sum;
  logic [2*W-1:0]    sat_y;
  logic              sat_flag;
  logic              last;

  assign acc_sum = acc_q + {{G{bus.p[2*W-1]}}, bus.p};
  assign last    = (cnt_q == CntLast);

  mac_acc_sat_trunc #(
    .InW  (AccW),
    .OutW (2 * W)
  ) u_sat (
    .a_i   (acc_sum),
    .y_o   (sat_y),
    .sat_o (sat_flag)
  );

  assign bus.in_ready  = (state_q == StAcc);
  assign busy_o        = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q  <= StAcc;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
          end
        end
        StAcc: begin
          // start wins over a product presented in the same cycle
          if (start_i) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
          end else if (bus.in_valid) begin
            acc_q    <= acc_sum;
            sticky_q <= sticky_q | bus.ser;
            cnt_q    <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
              state_q     <= StHold;
              y_q         <= sat_y;
              ovf_q       <= sticky_q | bus.ser | sat_flag;
              out_valid_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (start_i) begin
              state_q  <= StAcc;
              acc_q    <= '0;
              cnt_q    <= '0;
              sticky_q <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// Directed bench for mac_acc with W=16, G=8, N=4.
module tb_mac_acc;

  logic clk;
  logic arst_n;
  logic ce;
  logic start;
  logic busy;
  int   total;
  int   bad;

  mac_acc_if #(.W(16)) bus ();

  mac_acc #(
    .W (16),
    .G (8),
    .N (4)
  ) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .ce_i    (ce),
    .start_i (start),
    .bus     (bus),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_run();
    start        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] p, input logic s);
    bus.in_valid = 1'b1;
    bus.p        = p;
    bus.ser      = s;
    tick();
    bus.in_valid = 1'b0;
    bus.ser      = 1'b0;
  endtask

  task automatic run4(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] p3, input logic [31:0] exp_y, input logic exp_ovf,
                      input string tag);
    begin_run();
    feed(p0, 1'b0);
    feed(p1, 1'b0);
    feed(p2, 1'b0);
    feed(p3, 1'b0);
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_y"}, bus.y, exp_y);
    chk({tag, "_ovf"}, bus.ovf, exp_ovf);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    arst_n        = 1'b0;
    ce            = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.p         = '0;
    bus.ser       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_y", bus.y, 32'h0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    arst_n = 1'b1;
    tick();

    // Idle ignores in_valid
    bus.in_valid = 1'b1;
    bus.p        = 32'd9;
    tick();
    bus.in_valid = 1'b0;
    chk("idle_busy", busy, 1'b0);

    // Basic sum 1+2+3+4
    begin_run();
    chk("acc_in_ready", bus.in_ready, 1'b1);
    chk("acc_busy", busy, 1'b1);
    feed(32'd1, 1'b0);
    feed(32'd2, 1'b0);
    feed(32'd3, 1'b0);
    chk("basic_not_yet", bus.out_valid, 1'b0);
    feed(32'd4, 1'b0);
    chk("basic_valid", bus.out_valid, 1'b1);
    chk("basic_y", bus.y, 32'd10);
    chk("basic_ovf", bus.ovf, 1'b0);
    chk("hold_in_ready", bus.in_ready, 1'b0);
    take();
    chk("take_valid", bus.out_valid, 1'b0);
    chk("take_busy", busy, 1'b0);

    // Saturation and exact-limit boundaries
    run4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "possat");
    take();
    run4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, "negsat");
    take();
    run4(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 1'b0, "maxexact");
    take();
    run4(32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 1'b0, "minexact");
    take();
    // Intermediate excursion past 2^31-1 is absorbed by the guard bits
    run4(32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 1'b0, "guard");
    take();
    run4(32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h2, 32'h1, 32'hFFFF_FFFC, 1'b0, "negsum");
    take();

    // Sign-error flag is sticky across the run, cleared on the next
    begin_run();
    feed(32'd5, 1'b0);
    feed(32'd5, 1'b1);
    feed(32'd5, 1'b0);
    feed(32'd5, 1'b0);
    chk("ser_y", bus.y, 32'd20);
    chk("ser_ovf", bus.ovf, 1'b1);
    take();
    run4(32'd5, 32'd5, 32'd5, 32'd5, 32'd20, 1'b0, "ser_clear");

    // Backpressure in HOLD with in_valid high
    bus.in_valid = 1'b1;
    bus.p        = 32'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_y", bus.y, 32'd20);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    // ce low freezes HOLD even with out_ready
    ce            = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("ce_hold_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b0;
    ce            = 1'b1;
    take();

    // ce low for 3 cycles mid-ACC
    begin_run();
    feed(32'd1, 1'b0);
    feed(32'd2, 1'b0);
    ce           = 1'b0;
    bus.in_valid = 1'b1;
    bus.p        = 32'd50;
    repeat (3) tick();
    chk("ce_frozen_valid", bus.out_valid, 1'b0);
    chk("ce_frozen_busy", busy, 1'b1);
    ce = 1'b1;
    feed(32'd3, 1'b0);
    feed(32'd4, 1'b0);
    chk("ce_y", bus.y, 32'd10);
    chk("ce_ovf", bus.ovf, 1'b0);
    take();

    // Abort after 2 products; product under start is dropped
    begin_run();
    feed(32'd7, 1'b1);
    feed(32'd7, 1'b0);
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.p        = 32'd100;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    feed(32'd1, 1'b0);
    feed(32'd2, 1'b0);
    feed(32'd3, 1'b0);
    chk("abort_early", bus.out_valid, 1'b0);
    feed(32'd4, 1'b0);
    chk("abort_y", bus.y, 32'd10);
    chk("abort_ovf", bus.ovf, 1'b0);

    // out_ready and start together: next run begins next cycle
    bus.out_ready = 1'b1;
    start         = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    start         = 1'b0;
    chk("bb_valid", bus.out_valid, 1'b0);
    chk("bb_in_ready", bus.in_ready, 1'b1);
    feed(32'd2, 1'b0);
    feed(32'd2, 1'b0);
    feed(32'd2, 1'b0);
    feed(32'd2, 1'b0);
    chk("bb_y", bus.y, 32'd8);
    take();

    // Asynchronous reset mid-ACC
    begin_run();
    feed(32'd1, 1'b0);
    feed(32'd2, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_y", bus.y, 32'h0);
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b0);
    tick();
    arst_n = 1'b1;
    tick();
    run4(32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 1'b0, "post_rst");
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
